spi_xfer_seq: RTL and testbench
===============================

// Module: spi_xfer_seq
// PURPOSE
//  Transfer sequencer that sits directly upstream of spi_shift. It buffers outgoing words in a TX FIFO
//  and loads each word into the shift register. It then starts the transfer and waits for it to finish,
//  and pushes the received parallel word into an RX FIFO. This lets software or DMA stream characters
//  without polling tip. Character length, lsb and edge selection stay with the control register; this
//  block only handles data flow.
// PARAMETERS
//  DEPTH  4   entries per FIFO; power of two, >= 2
//  AW     2   log2(DEPTH); level outputs are AW+1 bits wide
//  DW     32  word width; equals `SPI_MAX_CHAR, so only latch[0] is used
// PORTS
//  clk          in   1     system clock
//  rst          in   1     synchronous reset, active-low
//  enable       in   1     allow new transfers to start
//  tx_data      in   DW    word to transmit
//  tx_valid     in   1     tx_data valid; push happens when tx_valid && tx_ready
//  tx_ready     out  1     TX FIFO not full
//  rx_data      out  DW    head of RX FIFO
//  rx_valid     out  1     RX FIFO not empty
//  rx_ready     in   1     consumer pop; pop happens when rx_valid && rx_ready
//  tx_level     out  AW+1  TX FIFO occupancy
//  rx_level     out  AW+1  RX FIFO occupancy
//  busy         out  1     FSM not in IDLE
//  sh_p_in      out  32    to spi_shift p_in
//  sh_latch     out  4     to spi_shift latch
//  sh_byte_sel  out  4     to spi_shift byte_sel
//  sh_go        out  1     to spi_shift go
//  sh_tip       in   1     from spi_shift tip
//  sh_p_out     in   DW    from spi_shift p_out
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//   - FSM goes to IDLE and both FIFOs empty.
//   - tx_ready=1, rx_valid=0, levels=0, busy=0.
//   - sh_latch=0, sh_byte_sel=0, sh_go=0, sh_p_in=0.
//   - A reset mid-transfer abandons the transfer; spi_shift is reset by the same system reset.
//  All outputs are registered except tx_ready, rx_valid, rx_data and the levels, which decode FIFO state.
//  FSM states and transitions:
//   - IDLE -> LOAD when enable && tx_level!=0 && rx_level<DEPTH && !sh_tip.
//   - LOAD, 1 cycle: sh_latch=4'b0001, sh_byte_sel=4'hF, sh_p_in=TX head; pop TX FIFO. -> GO.
//   - GO, 1 cycle: sh_go=1; sh_latch=0. -> RUN.
//   - RUN: sh_tip is already 1 here, since spi_shift sets tip one edge after go.
//     Stay in RUN while sh_tip==1; -> CAPT on the first cycle sh_tip==0.
//   - CAPT, 1 cycle: push sh_p_out into the RX FIFO (p_out is final one cycle after tip falls). -> IDLE.
//  Throughput and space:
//   - Minimum gap between transfers: IDLE+LOAD+GO = 3 clk.
//   - The RX slot is checked at start. With one transfer in flight, CAPT can never find RX full,
//     so no overrun path exists.
//  enable deasserted while busy: the current transfer completes through CAPT, then the FSM holds in IDLE.
//  FIFOs:
//   - Circular buffers with AW-bit read/write pointers that wrap modulo DEPTH.
//   - Occupancy counter is AW+1 bits. Full when count==DEPTH; empty when count==0.
//   - Push and pop in the same cycle: both take effect and the count is unchanged.
//     On a full FIFO, tx_ready=0 so no push occurs (no bypass). On an empty FIFO, no pop occurs.
//   - TX push while LOAD pops: legal and handled as above.
//   - rx_data is the registered array entry at the read pointer. It is undefined when rx_valid=0 and
//     must not be checked then.
// STRUCTURE
//  Sub-module spi_sync_fifo (params DW, AW), instantiated twice: u_tx_fifo and u_rx_fifo.
//  Ports: clk, rst, wr, wdata, rd, rdata, full, empty, level.
//  Shared constants go in spi_defines.v: SPI_XSEQ_IDLE/LOAD/GO/RUN/CAPT (3-bit state codes) and
//  SPI_XSEQ_DEPTH. The FSM and shift-port drive logic live in spi_xfer_seq.
// TESTING
//  Bench pairs the DUT with spi_shift and a loopback s_out->s_in.
//  Config: len=8, tx_negedge=1, rx_negedge=0, divider giving 4 clk per sclk.
//  1. Push 0x000000A5 with enable=1 -> one sh_go pulse, then rx_valid with rx_data[7:0]=0xA5;
//     tx_level 1->0, rx_level 0->1.
//  2. Push 4 words 0x11,0x22,0x33,0x44 back-to-back -> tx_ready=0 after the 4th push.
//     The RX FIFO returns 0x11,0x22,0x33,0x44 in order, with exactly 4 sh_go pulses.
//  3. Hold rx_ready=0 and push 6 words -> 4 transfers, then busy=0 with rx_level=4, tx_level=2.
//     Pop one -> exactly one more transfer starts.
//  4. Drop enable in the cycle after sh_go -> that transfer completes and is captured, and no further
//     sh_go occurs while tx_level>0.
//  5. Assert rst=0 for 1 cycle while in RUN -> the next cycle shows busy=0, levels=0, tx_ready=1,
//     rx_valid=0, and all sh_* outputs 0.
//  6. With TX full, assert a push in the same cycle as LOAD -> no push is accepted (tx_ready=0),
//     and tx_level goes 4->3.

Source files
------------

// File: rtl/spi_xfer_seq_pkg.sv
// Shared constants and state encoding for the SPI transfer sequencer.
// Contents: FIFO depth default and the 3-bit sequencer state codes.
package spi_xfer_seq_pkg;

    localparam int SPI_XSEQ_DEPTH = 4;

    typedef enum logic [2:0] {
        SPI_XSEQ_IDLE = 3'd0,
        SPI_XSEQ_LOAD = 3'd1,
        SPI_XSEQ_GO   = 3'd2,
        SPI_XSEQ_RUN  = 3'd3,
        SPI_XSEQ_CAPT = 3'd4
    } xseq_state_t;

endpackage

// File: rtl/spi_xfer_seq_if.sv
// Streaming TX/RX word interface of the SPI transfer sequencer.
// master: producer/consumer side; slave: the sequencer.
interface spi_xfer_seq_if #(
    parameter int DW = 32
);

    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output rx_ready,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  rx_ready,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// Ports: clk, rst (sync, active-low), wr/wdata, rd/rdata, full, empty, level.
module spi_sync_fifo #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    // Full and empty guard the pointers; no bypass through an empty FIFO.
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rp];
    assign level = cnt;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) begin
                wp <= wp + 1'b1;
            end
            if (do_rd) begin
                rp <= rp + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_seq.sv
// Transfer sequencer feeding spi_shift from a TX FIFO and collecting
// received words into an RX FIFO.
// Ports: clk, rst (sync, active-low), enable, bus (TX/RX stream),
// tx_level/rx_level, busy, sh_* (to/from spi_shift).
module spi_xfer_seq
    import spi_xfer_seq_pkg::*;
#(
    parameter int DEPTH = SPI_XSEQ_DEPTH,
    parameter int AW    = 2,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    spi_xfer_seq_if.slave      bus,
    output logic [AW:0]        tx_level,
    output logic [AW:0]        rx_level,
    output logic               busy,
    output logic [DW-1:0]      sh_p_in,
    output logic [3:0]         sh_latch,
    output logic [3:0]         sh_byte_sel,
    output logic               sh_go,
    input  logic               sh_tip,
    input  logic [DW-1:0]      sh_p_out
);

    xseq_state_t   state;
    logic [DW-1:0] tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic          tx_pop;
    logic          rx_push;
    logic          start;

    assign tx_pop  = (state == SPI_XSEQ_LOAD);
    assign rx_push = (state == SPI_XSEQ_CAPT);

    // RX space is reserved at start; with one transfer in
    // flight the capture can never meet a full RX FIFO.
    assign start = enable && !tx_empty && !sh_tip
                && (rx_level < (AW+1)'(DEPTH));

    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;

    spi_sync_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.tx_valid),
        .wdata (bus.tx_data),
        .rd    (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    spi_sync_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push),
        .wdata (sh_p_out),
        .rd    (bus.rx_ready),
        .rdata (bus.rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // Shift-port outputs are set on the transition into a
    // state so they are valid for the whole state cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SPI_XSEQ_IDLE;
            busy        <= 1'b0;
            sh_p_in     <= '0;
            sh_latch    <= '0;
            sh_byte_sel <= '0;
            sh_go       <= 1'b0;
        end else begin
            unique case (state)
                SPI_XSEQ_IDLE: begin
                    if (start) begin
                        state       <= SPI_XSEQ_LOAD;
                        busy        <= 1'b1;
                        sh_latch    <= 4'b0001;
                        sh_byte_sel <= 4'hF;
                        sh_p_in     <= tx_head;
                    end
                end
                SPI_XSEQ_LOAD: begin
                    state       <= SPI_XSEQ_GO;
                    sh_go       <= 1'b1;
                    sh_latch    <= '0;
                    sh_byte_sel <= '0;
                end
                SPI_XSEQ_GO: begin
                    state <= SPI_XSEQ_RUN;
                    sh_go <= 1'b0;
                end
                SPI_XSEQ_RUN: begin
                    if (!sh_tip) begin
                        state <= SPI_XSEQ_CAPT;
                    end
                end
                SPI_XSEQ_CAPT: begin
                    state <= SPI_XSEQ_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= SPI_XSEQ_IDLE;
                    busy  <= 1'b0;
                    sh_go <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq with a behavioural spi_shift
// stand-in (8-bit loopback, 4 clk per sclk, so tip lasts 32 clk).
module tb_spi_xfer_seq;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int TL = 32;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [AW:0]   tx_level;
    logic [AW:0]   rx_level;
    logic          busy;
    logic [DW-1:0] sh_p_in;
    logic [3:0]    sh_latch;
    logic [3:0]    sh_byte_sel;
    logic          sh_go;
    logic          sh_tip;
    logic [DW-1:0] sh_p_out;

    logic [DW-1:0] shreg;
    logic          cap_pend;
    int            tcnt;
    int            go_cnt;
    int            go_base;
    int            total;
    int            bad;

    spi_xfer_seq_if #(.DW(DW)) bus ();

    spi_xfer_seq #(
        .DEPTH (4),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .busy        (busy),
        .sh_p_in     (sh_p_in),
        .sh_latch    (sh_latch),
        .sh_byte_sel (sh_byte_sel),
        .sh_go       (sh_go),
        .sh_tip      (sh_tip),
        .sh_p_out    (sh_p_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // spi_shift stand-in: tip one edge after go, p_out final
    // one edge after tip falls, garbage while shifting.
    always @(posedge clk) begin
        if (!rst) begin
            sh_tip   <= 1'b0;
            sh_p_out <= '0;
            shreg    <= '0;
            cap_pend <= 1'b0;
            tcnt     <= 0;
        end else begin
            cap_pend <= 1'b0;
            if (sh_latch[0]) begin
                shreg <= sh_p_in;
            end
            if (sh_go) begin
                sh_tip   <= 1'b1;
                tcnt     <= TL;
                sh_p_out <= 32'hFFFF_FFFF;
            end else if (sh_tip) begin
                if (tcnt == 1) begin
                    sh_tip   <= 1'b0;
                    cap_pend <= 1'b1;
                end
                tcnt <= tcnt - 1;
            end
            if (cap_pend) begin
                sh_p_out <= shreg & 32'h0000_00FF;
            end
        end
    end

    initial go_cnt = 0;
    always @(posedge clk) begin
        if (sh_go) begin
            go_cnt = go_cnt + 1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        while (!bus.tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop(input string tag,
                       input logic [7:0] exp);
        logic [7:0] b;
        chk({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
        b = bus.rx_data[7:0];
        chk({tag, "_data"}, {24'd0, b}, {24'd0, exp});
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic wait_quiet(input string tag,
                              input int lvl);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        while (!ok && n < 600) begin
            @(negedge clk);
            n++;
            if (!busy && rx_level == (AW+1)'(lvl)) ok = 1;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_go(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sh_go && n < 200);
        chk(tag, {31'd0, sh_go}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        enable       = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        idle(2);
        rst = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_txrdy", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_rxval", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_txlvl", {29'd0, tx_level}, 32'd0);
        chk("rst_rxlvl", {29'd0, rx_level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_go", {31'd0, sh_go}, 32'd0);
        chk("rst_latch", {28'd0, sh_latch}, 32'd0);
        chk("rst_bsel", {28'd0, sh_byte_sel}, 32'd0);
        chk("rst_pin", sh_p_in, 32'd0);

        // 1: single word
        enable  = 1'b1;
        go_base = go_cnt;
        push(32'h0000_00A5);
        chk("t1_txlvl1", {29'd0, tx_level}, 32'd1);
        chk("t1_rxlvl0", {29'd0, rx_level}, 32'd0);
        wait_quiet("t1_done", 1);
        chk("t1_txlvl0", {29'd0, tx_level}, 32'd0);
        chk("t1_gos", go_cnt - go_base, 32'd1);
        pop("t1_pop", 8'hA5);
        chk("t1_rxlvl_end", {29'd0, rx_level}, 32'd0);

        // 2: four back-to-back words, in-order return
        do_reset();
        enable  = 1'b0;
        go_base = go_cnt;
        push(32'h11);
        push(32'h22);
        push(32'h33);
        push(32'h44);
        chk("t2_full", {31'd0, bus.tx_ready}, 32'd0);
        chk("t2_txlvl", {29'd0, tx_level}, 32'd4);
        enable = 1'b1;
        wait_quiet("t2_done", 4);
        chk("t2_gos", go_cnt - go_base, 32'd4);
        chk("t2_txlvl0", {29'd0, tx_level}, 32'd0);
        pop("t2_p0", 8'h11);
        pop("t2_p1", 8'h22);
        pop("t2_p2", 8'h33);
        pop("t2_p3", 8'h44);
        chk("t2_empty", {31'd0, bus.rx_valid}, 32'd0);

        // 3: RX backpressure stalls the sequencer
        do_reset();
        enable  = 1'b1;
        go_base = go_cnt;
        for (int i = 1; i <= 6; i++) begin
            push(32'h50 + i);
        end
        wait_quiet("t3_stall", 4);
        idle(60);
        chk("t3_gos", go_cnt - go_base, 32'd4);
        chk("t3_txlvl", {29'd0, tx_level}, 32'd2);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        pop("t3_p0", 8'h51);
        wait_quiet("t3_again", 4);
        idle(60);
        chk("t3_gos2", go_cnt - go_base, 32'd5);
        chk("t3_txlvl2", {29'd0, tx_level}, 32'd1);

        // 4: enable dropped mid-transfer
        do_reset();
        enable  = 1'b0;
        go_base = go_cnt;
        push(32'h61);
        push(32'h62);
        enable = 1'b1;
        wait_go("t4_go");
        @(negedge clk);
        enable = 1'b0;
        wait_quiet("t4_done", 1);
        idle(60);
        chk("t4_gos", go_cnt - go_base, 32'd1);
        chk("t4_txlvl", {29'd0, tx_level}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        pop("t4_p0", 8'h61);

        // 5: reset while in RUN
        do_reset();
        enable = 1'b0;
        push(32'h71);
        push(32'h72);
        enable = 1'b1;
        wait_go("t5_go");
        idle(3);
        chk("t5_busy_run", {31'd0, busy}, 32'd1);
        chk("t5_txlvl_run", {29'd0, tx_level}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_txlvl", {29'd0, tx_level}, 32'd0);
        chk("t5_rxlvl", {29'd0, rx_level}, 32'd0);
        chk("t5_txrdy", {31'd0, bus.tx_ready}, 32'd1);
        chk("t5_rxval", {31'd0, bus.rx_valid}, 32'd0);
        chk("t5_go", {31'd0, sh_go}, 32'd0);
        chk("t5_latch", {28'd0, sh_latch}, 32'd0);
        chk("t5_bsel", {28'd0, sh_byte_sel}, 32'd0);
        chk("t5_pin", sh_p_in, 32'd0);
        enable = 1'b0;

        // 6: push attempt on full TX during LOAD
        do_reset();
        enable = 1'b0;
        push(32'h81);
        push(32'h82);
        push(32'h83);
        push(32'h84);
        enable = 1'b1;
        @(negedge clk);
        bus.tx_data  = 32'h99;
        bus.tx_valid = 1'b1;
        chk("t6_latch", {28'd0, sh_latch}, 32'd1);
        chk("t6_bsel", {28'd0, sh_byte_sel}, 32'hF);
        chk("t6_pin", sh_p_in, 32'h81);
        chk("t6_txrdy", {31'd0, bus.tx_ready}, 32'd0);
        chk("t6_txlvl4", {29'd0, tx_level}, 32'd4);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("t6_txlvl3", {29'd0, tx_level}, 32'd3);
        chk("t6_go", {31'd0, sh_go}, 32'd1);
        wait_quiet("t6_done", 4);
        chk("t6_txlvl0", {29'd0, tx_level}, 32'd0);
        pop("t6_p0", 8'h81);
        pop("t6_p1", 8'h82);
        pop("t6_p2", 8'h83);
        pop("t6_p3", 8'h84);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
